// File: rtl/johnson_phase_monitor_if.sv
// Bus between the Johnson counter consumer and control/status logic.
// master drives enable/clear/counter state; slave (the monitor) returns status.
interface johnson_phase_monitor_if #(
  parameter int CNT_W = 8
);
  logic             En;
  logic             Clr;
  logic [3:0]       Q_in;
  logic [2:0]       Phase;
  logic             Phase_vld;
  logic             Wrap_pulse;
  logic [CNT_W-1:0] Wrap_cnt;
  logic             Err;
  logic             Stall;
  logic [1:0]       State;

  modport master (
    output En, Clr, Q_in,
    input  Phase, Phase_vld, Wrap_pulse, Wrap_cnt, Err, Stall, State
  );

  modport slave (
    input  En, Clr, Q_in,
    output Phase, Phase_vld, Wrap_pulse, Wrap_cnt, Err, Stall, State
  );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: registers the 4-bit counter bus, tracks the
// legal 8-step sequence, counts full periods and flags illegal steps / stalls.
// All status outputs come straight from flops.
module johnson_phase_monitor #(
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 16
) (
  input logic                   Clk,
  input logic                   Rst,
  johnson_phase_monitor_if.slave bus
);

  localparam logic [1:0] HUNT   = 2'b00;
  localparam logic [1:0] LOCKED = 2'b01;
  localparam logic [1:0] ERROR  = 2'b10;
  localparam logic [7:0] HOLD_MAX = 8'(STALL_MAX);

  // Johnson code for a given phase index.
  function automatic logic [3:0] code_of(input logic [2:0] ph);
    case (ph)
      3'd0:    code_of = 4'b0000;
      3'd1:    code_of = 4'b0001;
      3'd2:    code_of = 4'b0011;
      3'd3:    code_of = 4'b0111;
      3'd4:    code_of = 4'b1111;
      3'd5:    code_of = 4'b1110;
      3'd6:    code_of = 4'b1100;
      default: code_of = 4'b1000;
    endcase
  endfunction

  logic [3:0]       q_r, q_p;
  logic [1:0]       state, state_n;
  logic [2:0]       phase, phase_n, phase_inc;
  logic             vld;
  logic             pulse, pulse_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;
  logic             err, err_n;
  logic             stall, stall_n;
  logic [7:0]       hold, hold_n;

  assign phase_inc = phase + 3'd1;

  // Input pipeline: current code and the one before it, compared for hold/step.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_r <= 4'b0000;
      q_p <= 4'b0000;
    end else begin
      q_r <= bus.Q_in;
      q_p <= q_r;
    end
  end

  // Next-state logic; Clr beats En=0, which beats the sequence checker.
  always_comb begin
    state_n = state;
    phase_n = phase;
    pulse_n = 1'b0;
    wcnt_n  = wcnt;
    err_n   = err;
    stall_n = stall;
    hold_n  = hold;
    if (bus.Clr) begin
      state_n = HUNT;
      err_n   = 1'b0;
      stall_n = 1'b0;
      wcnt_n  = '0;
      hold_n  = '0;
    end else if (!bus.En && state != ERROR) begin
      state_n = HUNT;
      stall_n = 1'b0;
      hold_n  = '0;
    end else begin
      case (state)
        HUNT: begin
          // Only the all-zero code is a safe place to start tracking.
          if (q_r == 4'b0000) begin
            state_n = LOCKED;
            phase_n = 3'd0;
          end
        end
        LOCKED: begin
          if (q_r == q_p) begin
            if (hold < HOLD_MAX) hold_n = hold + 8'd1;
            if (hold_n == HOLD_MAX) stall_n = 1'b1;
          end else if (q_r == code_of(phase_inc)) begin
            phase_n = phase_inc;
            hold_n  = '0;
            stall_n = 1'b0;
            if (phase == 3'd7) begin
              pulse_n = 1'b1;
              if (wcnt != {CNT_W{1'b1}}) wcnt_n = wcnt + 1'b1;
            end
          end else begin
            // Skipped, backward or illegal code; Phase keeps last good value.
            state_n = ERROR;
            err_n   = 1'b1;
            stall_n = 1'b0;
            hold_n  = '0;
          end
        end
        default: begin
          state_n = ERROR;
          err_n   = 1'b1;
        end
      endcase
    end
  end

  // State and status registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= HUNT;
      phase <= 3'd0;
      vld   <= 1'b0;
      pulse <= 1'b0;
      wcnt  <= '0;
      err   <= 1'b0;
      stall <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      vld   <= (state_n == LOCKED);
      pulse <= pulse_n;
      wcnt  <= wcnt_n;
      err   <= err_n;
      stall <= stall_n;
      hold  <= hold_n;
    end
  end

  assign bus.State      = state;
  assign bus.Phase      = phase;
  assign bus.Phase_vld  = vld;
  assign bus.Wrap_pulse = pulse;
  assign bus.Wrap_cnt   = wcnt;
  assign bus.Err        = err;
  assign bus.Stall      = stall;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor. Two instances share stimulus:
// CNT_W=8 for the main checks and CNT_W=2 for wrap counter saturation.
module tb_johnson_phase_monitor;
  localparam int STALL_MAX = 16;
  localparam logic [1:0] ST_H = 2'b00, ST_L = 2'b01, ST_E = 2'b10;

  typedef struct {
    int         due;
    logic [1:0] st;
    logic [2:0] ph;
    logic       phc;
    logic       vld;
    logic       pul;
    int         wc;
    logic       err;
    logic       stl;
    string      tag;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   idx = 0;
  logic pend_en = 1'b0;
  logic pend_clr = 1'b0;
  string sect = "init";
  exp_t sb[$];

  johnson_phase_monitor_if #(.CNT_W(8)) b1 ();
  johnson_phase_monitor_if #(.CNT_W(2)) b2 ();

  johnson_phase_monitor #(.CNT_W(8), .STALL_MAX(STALL_MAX)) dut (
    .Clk(Clk), .Rst(Rst), .bus(b1.slave));
  johnson_phase_monitor #(.CNT_W(2), .STALL_MAX(STALL_MAX)) dut2 (
    .Clk(Clk), .Rst(Rst), .bus(b2.slave));

  assign b2.En   = b1.En;
  assign b2.Clr  = b1.Clr;
  assign b2.Q_in = b1.Q_in;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  function automatic logic [3:0] jcode(input int k);
    case (k % 8)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      4: return 4'b1111;
      5: return 4'b1110;
      6: return 4'b1100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [16:0] pk(input logic [1:0] st, input logic [2:0] ph,
      input logic v, input logic p, input logic e, input logic s, input logic [7:0] wc);
    return {st, ph, v, p, e, s, wc};
  endfunction

  task automatic cmp(input string nm, input logic [16:0] a, input logic [16:0] x);
    n_vec++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s got=%05h want=%05h (st,ph,vld,pul,err,stl,wc8)", nm, a, x);
    end
  endtask

  task automatic chk_rst(input string nm);
    cmp({nm, ".w8"}, pk(b1.State, b1.Phase, b1.Phase_vld, b1.Wrap_pulse, b1.Err, b1.Stall,
        b1.Wrap_cnt), pk(ST_H, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    cmp({nm, ".w2"}, pk(b2.State, b2.Phase, b2.Phase_vld, b2.Wrap_pulse, b2.Err, b2.Stall,
        {6'd0, b2.Wrap_cnt}), pk(ST_H, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
  endtask

  // Monitor: outputs appear every cycle; compare whatever expectations mature now.
  always @(negedge Clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        exp_t e;
        int   wc2;
        e = sb[i];
        wc2 = (e.wc > 3) ? 3 : e.wc;
        cmp({e.tag, ".w8"},
            pk(b1.State, e.phc ? b1.Phase : 3'd0, b1.Phase_vld, b1.Wrap_pulse, b1.Err,
               b1.Stall, b1.Wrap_cnt),
            pk(e.st, e.phc ? e.ph : 3'd0, e.vld, e.pul, e.err, e.stl, 8'(e.wc)));
        cmp({e.tag, ".w2"},
            pk(b2.State, e.phc ? b2.Phase : 3'd0, b2.Phase_vld, b2.Wrap_pulse, b2.Err,
               b2.Stall, {6'd0, b2.Wrap_cnt}),
            pk(e.st, e.phc ? e.ph : 3'd0, e.vld, e.pul, e.err, e.stl, 8'(wc2)));
        sb.delete(i);
      end
    end
  end

  // One vector: Q now; en/clr ride along to the edge that evaluates this Q.
  // Expected values describe the outputs after that evaluation (2 clocks).
  task automatic tick(input logic [3:0] q, input logic en, input logic clr,
      input logic [1:0] st, input logic [2:0] ph, input logic phc, input logic v,
      input logic p, input int wc, input logic e, input logic s);
    exp_t x;
    b1.Q_in = q;
    b1.En   = pend_en;
    b1.Clr  = pend_clr;
    pend_en  = en;
    pend_clr = clr;
    x.due = cyc + 2; x.st = st; x.ph = ph; x.phc = phc; x.vld = v; x.pul = p;
    x.wc = wc; x.err = e; x.stl = s;
    x.tag = $sformatf("%s#%0d", sect, idx);
    idx++;
    sb.push_back(x);
    @(negedge Clk);
  endtask

  task automatic lk(input logic [3:0] q, input logic [2:0] ph, input logic p,
      input int wc, input logic s);
    tick(q, 1'b1, 1'b0, ST_L, ph, 1'b1, 1'b1, p, wc, 1'b0, s);
  endtask

  task automatic periods(input int n, input int wc0);
    for (int p = 0; p < n; p++)
      for (int k = 1; k <= 8; k++)
        lk(jcode(k), 3'(k % 8), k == 8, wc0 + p + ((k == 8) ? 1 : 0), 1'b0);
  endtask

  initial begin
    b1.Q_in = 4'b0000; b1.En = 1'b0; b1.Clr = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    chk_rst("reset");
    @(negedge Clk);
    b1.En = 1'b1; pend_en = 1'b1;
    Rst = 1'b0;

    sect = "lock";
    lk(4'b0000, 3'd0, 1'b0, 0, 1'b0);

    sect = "seq3";
    periods(3, 0);

    sect = "skip";
    lk(4'b0001, 3'd1, 1'b0, 3, 1'b0);
    lk(4'b0011, 3'd2, 1'b0, 3, 1'b0);
    tick(4'b1111, 1, 0, ST_E, 3'd2, 1, 0, 0, 3, 1, 0);
    tick(4'b0000, 1, 0, ST_E, 3'd2, 1, 0, 0, 3, 1, 0);
    tick(4'b0001, 1, 0, ST_E, 3'd2, 1, 0, 0, 3, 1, 0);
    tick(4'b0000, 1, 1, ST_H, 3'd0, 0, 0, 0, 0, 0, 0);
    lk(4'b0000, 3'd0, 1'b0, 0, 1'b0);

    sect = "stall";
    lk(4'b0001, 3'd1, 1'b0, 0, 1'b0);
    lk(4'b0011, 3'd2, 1'b0, 0, 1'b0);
    lk(4'b0111, 3'd3, 1'b0, 0, 1'b0);
    for (int j = 1; j <= STALL_MAX + 2; j++)
      lk(4'b0111, 3'd3, 1'b0, 0, j >= STALL_MAX);
    lk(4'b1111, 3'd4, 1'b0, 0, 1'b0);
    lk(4'b1110, 3'd5, 1'b0, 0, 1'b0);
    lk(4'b1100, 3'd6, 1'b0, 0, 1'b0);
    lk(4'b1000, 3'd7, 1'b0, 0, 1'b0);
    lk(4'b0000, 3'd0, 1'b1, 1, 1'b0);

    sect = "clr_ill";
    tick(4'b0101, 1, 1, ST_H, 3'd0, 0, 0, 0, 0, 0, 0);
    tick(4'b0101, 1, 0, ST_H, 3'd0, 0, 0, 0, 0, 0, 0);
    lk(4'b0000, 3'd0, 1'b0, 0, 1'b0);

    sect = "en_off";
    periods(1, 0);
    tick(4'b0001, 0, 0, ST_H, 3'd0, 0, 0, 0, 1, 0, 0);
    lk(4'b0000, 3'd0, 1'b0, 1, 1'b0);

    sect = "sat";
    periods(4, 1);

    sect = "async";
    lk(4'b0001, 3'd1, 1'b0, 5, 1'b0);
    lk(4'b0011, 3'd2, 1'b0, 5, 1'b0);
    #3 Rst = 1'b1;
    sb.delete();
    #1 chk_rst("async_rst");
    @(negedge Clk);
    @(negedge Clk);
    b1.Q_in = 4'b0000; b1.Clr = 1'b0; pend_en = 1'b1; pend_clr = 1'b0;
    Rst = 1'b0;
    sect = "relock";
    lk(4'b0000, 3'd0, 1'b0, 0, 1'b0);
    lk(4'b0001, 3'd1, 1'b0, 0, 1'b0);
    lk(4'b0011, 3'd2, 1'b0, 0, 1'b0);

    b1.En = pend_en; b1.Clr = pend_clr;
    repeat (3) @(negedge Clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
